// File: rtl/ilog_unit.sv
// ilog_unit: iterative floor(log_base(value)) engine.
// Each CALC cycle does one multiply-compare against the captured value.
// Optional feature macro: ILOG_REM_EN adds the `rem` output (value - base^result).
module ilog_unit #(
  parameter int unsigned W     = 16,
  parameter int unsigned EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     base,
  input  logic [W-1:0]     value,
  output logic             busy,
  output logic             done,
  output logic [EXP_W-1:0] result,
`ifdef ILOG_REM_EN
  output logic             err,
  output logic [W-1:0]     rem
`else
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]     base_q;
  logic [W-1:0]     val_q;
  logic [W-1:0]     acc;
  logic [EXP_W-1:0] e;

  logic [2*W-1:0]   prod;
  logic             fits;
  logic             op_err;

  // Full-width product: acc <= value < 2^W, so 2W bits never overflow.
  assign prod   = {{W{1'b0}}, acc} * {{W{1'b0}}, base_q};
  assign fits   = (prod <= {{W{1'b0}}, val_q});
  assign op_err = (base < W'(2)) || (value == '0);

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // State register; reset discards any in-flight job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: illegal operands skip CALC and report straight away.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op_err ? FIN : CALC;
      CALC:    if (!fits) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: operand capture and the acc/e iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      val_q  <= '0;
      acc    <= '0;
      e      <= '0;
    end else begin
      if (state == IDLE && start && !op_err) begin
        base_q <= base;
        val_q  <= value;
        acc    <= W'(1);
        e      <= '0;
      end else if (state == CALC && fits) begin
        acc <= prod[W-1:0];
        e   <= e + 1'b1;
      end
    end
  end

  // Visible results change only on entry to FIN and hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      err    <= 1'b0;
    end else if (state == IDLE && start && op_err) begin
      result <= '0;
      err    <= 1'b1;
    end else if (state == CALC && !fits) begin
      result <= e;
      err    <= 1'b0;
    end
  end

`ifdef ILOG_REM_EN
  // Remainder: acc equals base^result when CALC stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               rem <= '0;
    else if (state == IDLE && start && op_err) rem <= '0;
    else if (state == CALC && !fits)           rem <= val_q - acc;
  end
`endif

endmodule

// File: tb/tb_ilog_unit.sv
// Self-checking bench for ilog_unit: directed cases plus random jobs
// against a plain-arithmetic floor-log model.
module tb_ilog_unit;

  localparam int W     = 16;
  localparam int EXP_W = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     base;
  logic [W-1:0]     value;
  logic             busy;
  logic             done;
  logic [EXP_W-1:0] result;
  logic             err;
`ifdef ILOG_REM_EN
  logic [W-1:0]     rem;
`endif

  int checks   = 0;
  int failures = 0;

  ilog_unit #(.W(W), .EXP_W(EXP_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .value  (value),
    .busy   (busy),
    .done   (done),
    .result (result),
`ifdef ILOG_REM_EN
    .err    (err),
    .rem    (rem)
`else
    .err    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: largest e with b^e <= v, by repeated multiplication.
  task automatic model(input int b, input int v, output int r, output int e, output int rm);
    longint p;
    if (b < 2 || v == 0) begin
      r = 0; e = 1; rm = 0;
    end else begin
      r = 0; e = 0; p = b;
      while (p <= v) begin
        r++;
        p = p * b;
      end
      rm = v - int'(p / b);
    end
  endtask

  // Run one job. repulse>0 asserts start (with other operands) in that
  // cycle after acceptance; cycle 1 is the first cycle after the accept edge.
  task automatic job(input int b, input int v, input int repulse, input string tag);
    int r, e, rm, lat, dcyc;
    model(b, v, r, e, rm);
    lat  = (e != 0) ? 1 : r + 2;
    dcyc = -1;
    @(posedge clk); #1;
    base = W'(b); value = W'(v); start = 1'b1;
    chk({tag, ":idle_busy"}, busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    base = ~W'(b); value = ~W'(v);   // operands must already be captured
    for (int cyc = 1; cyc <= 80; cyc++) begin
      chk({tag, ":busy"}, busy, 1);
      if (cyc == repulse) begin
        start = 1'b1; base = W'(3); value = W'(5);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, ":latency"}, dcyc, lat);
    chk({tag, ":result"}, result, r);
    chk({tag, ":err"}, err, e);
`ifdef ILOG_REM_EN
    chk({tag, ":rem"}, rem, rm);
`endif
    // done must be a single pulse and the unit must return to IDLE.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ":done_pulse"}, done, 0);
      chk({tag, ":idle_after"}, busy, 0);
      chk({tag, ":held"}, result, r);
    end
  endtask

  initial begin
    int rb, rv;
    start = 1'b0; base = '0; value = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
`ifdef ILOG_REM_EN
    chk("rst_rem", rem, 0);
`endif
    rst_n = 1'b1;

    job(3, 80, 0, "b3_v80");
    job(2, 16'hFFFF, 0, "b2_max");
    job(255, 16'hFFFF, 0, "b255_max");
    job(1, 100, 0, "err_b1");
    job(10, 0, 0, "err_v0");
    job(10, 1, 0, "b10_v1");
    job(0, 50, 0, "err_b0");
    job(16'hFFFF, 16'hFFFF, 0, "bmax_vmax");
    job(2, 1000, 3, "repulse_calc");
    job(7, 400, 5, "repulse_fin");     // start held during the FIN cycle
    job(1, 9, 1, "repulse_errfin");

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    base = W'(2); value = W'(1000); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("midrst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_err", err, 0);
`ifdef ILOG_REM_EN
    chk("midrst_rem", rem, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
    end
    job(10, 999, 0, "after_rst");

    // Random jobs; bases biased small so results are non-trivial.
    for (int i = 0; i < 25; i++) begin
      rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12));
      rv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
      job(rb, rv, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
